// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - FWD_* : ALU operand forwarding select encodings
//   - hz_state_e : hazard controller sequencing states
//   - hz_ctrl_t : bundle of the stall/flush strobes driven to the pipeline registers
//   - run_ctrl / freeze_ctrl : the two strobe patterns the controller can emit
package pipeline_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from ResultW
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from ALUResultM

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_TIMEOUT  = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } hz_ctrl_t;

    // Normal flow: a taken branch suppresses the load-use stall (lw already
    // excludes pc_src_e), so the PC is free to take the branch target.
    function automatic hz_ctrl_t run_ctrl(input logic lw, input logic br);
        hz_ctrl_t c;
        c         = '0;
        c.stall_f = lw;
        c.stall_d = lw;
        c.flush_e = lw | br;
        c.flush_d = br;
        return c;
    endfunction

    // Whole-pipeline hold while data memory is busy. Writeback gets a bubble
    // so the held Memory instruction is not retired more than once.
    function automatic hz_ctrl_t freeze_ctrl();
        hz_ctrl_t c;
        c         = '0;
        c.stall_f = 1'b1;
        c.stall_d = 1'b1;
        c.stall_e = 1'b1;
        c.stall_m = 1'b1;
        c.flush_w = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding select for one ALU source.
// Ports:
//   rs_e        : source register of the Execute instruction
//   rd_m        : destination register in Memory, reg_write_m its write enable
//   rd_w        : destination register in Writeback, reg_write_w its write enable
//   fwd_sel     : FWD_MEM / FWD_WB / FWD_RF
module hazard_fwd_sel
    import pipeline_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd_sel
);

    logic hit_m;
    logic hit_w;

    // x0 is hardwired to zero, so writes to it never forward.
    assign hit_m = reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e);
    assign hit_w = reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e);

    // Memory holds the younger result, so it wins over Writeback.
    always_comb begin
        fwd_sel = FWD_RF;
        if (hit_m) begin
            fwd_sel = FWD_MEM;
        end else if (hit_w) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage F/D/E/M/W core.
//   - Forwarding selects for both ALU operands (combinational).
//   - Load-use stall and taken-branch flush.
//   - Full pipeline freeze while a data-memory access waits on dmem_ready,
//     with a timeout after MAX_WAIT frozen cycles (sticky mem_err).
//   - Saturating stall / flush performance counters.
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   rs1_d, rs2_d                    : Decode source registers
//   rs1_e, rs2_e, rd_e, result_src_e: Execute sources / dest / is-load
//   pc_src_e                        : taken branch resolved in Execute
//   rd_m, reg_write_m, mem_access_m : Memory dest / write enable / is-ld-st
//   dmem_ready                      : data memory completes this cycle
//   rd_w, reg_write_w               : Writeback dest / write enable
//   forward_a_e, forward_b_e        : operand selects
//   stall_*, flush_*                : pipeline register controls
//   mem_err                         : sticky timeout flag
//   stall_cnt, flush_cnt            : saturating perf counters
// MAX_WAIT must be at least 2.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             result_src_e,
    input  logic             pc_src_e,
    input  logic [4:0]       rd_m,
    input  logic             reg_write_m,
    input  logic             mem_access_m,
    input  logic             dmem_ready,
    input  logic [4:0]       rd_w,
    input  logic             reg_write_w,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT);

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    hz_ctrl_t          ctrl;
    logic              lw;
    logic              freeze_req;
    logic              any_stall;

    // ---------------- forwarding ----------------
    hazard_fwd_sel u_fwd_a (
        .rs_e        (rs1_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd_sel     (forward_a_e)
    );

    hazard_fwd_sel u_fwd_b (
        .rs_e        (rs2_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd_sel     (forward_b_e)
    );

    // ---------------- hazard detection ----------------
    // A taken branch squashes the Decode instruction anyway, so a load-use
    // stall on it would only delay the redirect.
    assign lw = result_src_e && (rd_e != 5'd0) &&
                ((rd_e == rs1_d) || (rd_e == rs2_d)) && !pc_src_e;

    assign freeze_req = mem_access_m && !dmem_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HZ_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // wait_cnt counts frozen cycles already spent; the RUN cycle that starts
    // the freeze is the first, so the timeout lands on frozen cycle MAX_WAIT.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            HZ_RUN: begin
                if (freeze_req) begin
                    state_d    = HZ_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            HZ_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = HZ_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
                    state_d   = HZ_TIMEOUT;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            HZ_TIMEOUT: begin
                // Only reset leaves TIMEOUT; dmem_ready is ignored.
            end
            default: begin
                state_d    = HZ_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // While frozen, Execute is held, so a pending pc_src_e remains asserted
    // and its flush is issued on the release cycle instead of being lost.
    always_comb begin
        ctrl = run_ctrl(lw, pc_src_e);
        case (state_q)
            HZ_RUN:      if (freeze_req)  ctrl = freeze_ctrl();
            HZ_MEM_WAIT: if (!dmem_ready) ctrl = freeze_ctrl();
            HZ_TIMEOUT:  ctrl = freeze_ctrl();
            default:     ctrl = run_ctrl(lw, pc_src_e);
        endcase
    end

    assign stall_f = ctrl.stall_f;
    assign stall_d = ctrl.stall_d;
    assign stall_e = ctrl.stall_e;
    assign stall_m = ctrl.stall_m;
    assign flush_d = ctrl.flush_d;
    assign flush_e = ctrl.flush_e;
    assign flush_w = ctrl.flush_w;

    // ---------------- performance counters ----------------
    assign any_stall = ctrl.stall_f | ctrl.stall_d | ctrl.stall_e | ctrl.stall_m;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (any_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ctrl.flush_d && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl. A stimulus process drives one
// input vector per cycle, evaluates a reference model of the controller and
// queues the expected outputs; a monitor pops and compares on the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam int MAX_WAIT = 16;
    localparam int CNT_W    = 6;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic             result_src_e, pc_src_e, reg_write_m, mem_access_m;
    logic             dmem_ready, reg_write_w;
    logic [1:0]       forward_a_e, forward_b_e;
    logic             stall_f, stall_d, stall_e, stall_m;
    logic             flush_d, flush_e, flush_w, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .result_src_e(result_src_e), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_access_m(mem_access_m),
        .dmem_ready(dmem_ready), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        bit       rst;
        bit [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        bit       result_src_e, pc_src_e, reg_write_m, mem_access_m, dmem_ready, reg_write_w;
    } stim_t;

    typedef struct {
        int fa, fb;
        bit sf, sd, se, sm, fd, fe, fw, err;
        int sc, fc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: consecutive frozen cycles seen, timeout flag,
    // and the two event counts.
    int   waited    = 0;
    bit   timed_out = 0;
    int   m_stall   = 0;
    int   m_flush   = 0;

    function automatic int fwd_ref(bit [4:0] rs, bit [4:0] rdm, bit wm, bit [4:0] rdw, bit ww);
        if (wm && rdm != 0 && rdm == rs) return 2;
        if (ww && rdw != 0 && rdw == rs) return 1;
        return 0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.rst = 1'b1;
        s.dmem_ready = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        bit   lw, frozen;
        @(posedge clk);
        #1;
        rst = s.rst;
        rs1_d = s.rs1_d; rs2_d = s.rs2_d; rs1_e = s.rs1_e; rs2_e = s.rs2_e;
        rd_e = s.rd_e; rd_m = s.rd_m; rd_w = s.rd_w;
        result_src_e = s.result_src_e; pc_src_e = s.pc_src_e;
        reg_write_m = s.reg_write_m; mem_access_m = s.mem_access_m;
        dmem_ready = s.dmem_ready; reg_write_w = s.reg_write_w;

        if (!s.rst) begin
            waited = 0; timed_out = 0; m_stall = 0; m_flush = 0;
        end
        e = '{default: 0};
        e.err = timed_out;
        e.sc  = m_stall;
        e.fc  = m_flush;
        e.fa  = fwd_ref(s.rs1_e, s.rd_m, s.reg_write_m, s.rd_w, s.reg_write_w);
        e.fb  = fwd_ref(s.rs2_e, s.rd_m, s.reg_write_m, s.rd_w, s.reg_write_w);
        lw = s.result_src_e && s.rd_e != 0 && (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d) && !s.pc_src_e;
        // Frozen while timed out, or while a memory access (new or already
        // waiting) has not been acknowledged.
        frozen = timed_out || ((waited > 0 || s.mem_access_m) && !s.dmem_ready);
        if (frozen) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
        end else begin
            e.sf = lw; e.sd = lw; e.fe = lw || s.pc_src_e; e.fd = s.pc_src_e;
        end
        exp_q.push_back(e);

        if (s.rst) begin
            if (frozen) begin
                waited++;
                if (waited >= MAX_WAIT) timed_out = 1;
            end else begin
                waited = 0;
            end
            if ((e.sf || e.sd || e.se || e.sm) && m_stall < CNT_MAX) m_stall++;
            if (e.fd && m_flush < CNT_MAX) m_flush++;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("forward_a_e", int'(forward_a_e), mon_e.fa);
            chk("forward_b_e", int'(forward_b_e), mon_e.fb);
            chk("stall_f", int'(stall_f), int'(mon_e.sf));
            chk("stall_d", int'(stall_d), int'(mon_e.sd));
            chk("stall_e", int'(stall_e), int'(mon_e.se));
            chk("stall_m", int'(stall_m), int'(mon_e.sm));
            chk("flush_d", int'(flush_d), int'(mon_e.fd));
            chk("flush_e", int'(flush_e), int'(mon_e.fe));
            chk("flush_w", int'(flush_w), int'(mon_e.fw));
            chk("mem_err", int'(mem_err), int'(mon_e.err));
            chk("stall_cnt", int'(stall_cnt), mon_e.sc);
            chk("flush_cnt", int'(flush_cnt), mon_e.fc);
        end
    end

    initial begin
        stim_t s;
        rst = 1'b0;
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        result_src_e = 0; pc_src_e = 0; reg_write_m = 0; mem_access_m = 0;
        dmem_ready = 1; reg_write_w = 0;

        // Reset state
        s = idle(); s.rst = 0;
        repeat (2) apply(s);
        apply(idle());

        // Forwarding priority and x0 exclusion
        s = idle();
        s.rd_m = 5; s.rd_w = 5; s.reg_write_m = 1; s.reg_write_w = 1; s.rs1_e = 5; s.rs2_e = 5;
        apply(s);
        s.reg_write_m = 0; apply(s);
        s.rd_m = 0; s.rd_w = 0; s.reg_write_m = 1; apply(s);

        // Load-use for one cycle
        s = idle(); s.result_src_e = 1; s.rd_e = 7; s.rs2_d = 7;
        apply(s);
        apply(idle());

        // Load-use plus taken branch: branch wins
        s.pc_src_e = 1;
        apply(s);
        apply(idle());

        // Three-cycle memory wait then release
        s = idle(); s.mem_access_m = 1; s.dmem_ready = 0;
        repeat (3) apply(s);
        s.dmem_ready = 1; apply(s);
        apply(idle());

        // Branch arriving during a freeze is flushed on release
        s = idle(); s.mem_access_m = 1; s.dmem_ready = 0;
        apply(s);
        s.pc_src_e = 1;
        repeat (2) apply(s);
        s.dmem_ready = 1; apply(s);
        apply(idle());

        // Timeout: held past MAX_WAIT, dmem_ready ignored afterwards, async reset
        s = idle(); s.mem_access_m = 1; s.dmem_ready = 0;
        repeat (MAX_WAIT + 3) apply(s);
        s.dmem_ready = 1; repeat (2) apply(s);
        s.rst = 0; s.dmem_ready = 0; s.mem_access_m = 0; s.pc_src_e = 1;
        apply(s);
        apply(idle());

        // Long load-use run to drive stall_cnt into saturation
        s = idle(); s.result_src_e = 1; s.rd_e = 3; s.rs1_d = 3;
        repeat (CNT_MAX + 6) apply(s);
        s = idle(); s.rst = 0; apply(s);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s.rst          = ($urandom_range(0, 299) != 0);
            s.rs1_d        = 5'($urandom_range(0, 3));
            s.rs2_d        = 5'($urandom_range(0, 3));
            s.rs1_e        = 5'($urandom_range(0, 3));
            s.rs2_e        = 5'($urandom_range(0, 3));
            s.rd_e         = 5'($urandom_range(0, 3));
            s.rd_m         = 5'($urandom_range(0, 3));
            s.rd_w         = 5'($urandom_range(0, 3));
            s.result_src_e = 1'($urandom_range(0, 1));
            s.pc_src_e     = ($urandom_range(0, 3) == 0);
            s.reg_write_m  = 1'($urandom_range(0, 1));
            s.reg_write_w  = 1'($urandom_range(0, 1));
            s.mem_access_m = ($urandom_range(0, 3) == 0);
            s.dmem_ready   = ($urandom_range(0, 2) != 0);
            apply(s);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual=%0d pending expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
